fstage_fetch: RTL and testbench

FSTAGE_FETCH -- requirements
Module: fstage_fetch

---
 rtl/fstage_fetch.sv | 158 +++++++++++++++
 tb/tb_fstage_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fstage_fetch.sv
// Instruction fetch stage: takes the next PC from write-back, issues one
// read on the instruction bus, and presents {pc, instruction, pc+4, status}
// to decode. At most one read is ever outstanding; a misaligned PC is
// reported as a fault without touching the bus.
module fstage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  // next PC from write-back
  input  logic [31:0] dnpc,
  input  logic        s_valid,
  output logic        s_ready,
  // instruction bus, read-address channel
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  // instruction bus, read-data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  // towards decode
  output logic [31:0] pcF,
  output logic [31:0] instF,
  output logic [31:0] snpcF,
  output logic [1:0]  faultF,
  output logic        m_valid,
  input  logic        m_ready
);

  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    ADDR      = 3'd1,
    WAIT_DATA = 3'd2,
    OUT       = 3'd3,
    WAIT_PC   = 3'd4
  } state_t;

  localparam logic [1:0] FAULT_OK    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_BUS   = 2'b10;

  state_t state_r;
  state_t state_nx_s;

  // Sequential PC: wraps naturally at 2^32.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // A PC that is not word aligned cannot be fetched.
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  // State register; reset abandons any in-flight bus transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: each state only looks at its own handshake input.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      BOOT: begin
        state_nx_s = ADDR;
      end
      ADDR: begin
        if (arready) begin
          state_nx_s = WAIT_DATA;
        end else begin
          state_nx_s = ADDR;
        end
      end
      WAIT_DATA: begin
        if (rvalid) begin
          state_nx_s = OUT;
        end else begin
          state_nx_s = WAIT_DATA;
        end
      end
      OUT: begin
        if (m_ready) begin
          state_nx_s = WAIT_PC;
        end else begin
          state_nx_s = OUT;
        end
      end
      WAIT_PC: begin
        if (s_valid) begin
          if (pc_misaligned(dnpc)) begin
            state_nx_s = OUT;
          end else begin
            state_nx_s = ADDR;
          end
        end else begin
          state_nx_s = WAIT_PC;
        end
      end
      default: begin
        state_nx_s = BOOT;
      end
    endcase
  end

  // Fetch payload registers: captured on data return or on PC accept,
  // held untouched while decode is being offered the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcF    <= RESET_PC;
      snpcF  <= RESET_PC + 32'd4;
      instF  <= 32'd0;
      faultF <= FAULT_OK;
    end else begin
      case (state_r)
        WAIT_DATA: begin
          if (rvalid) begin
            instF  <= rdata;
            faultF <= (rresp != 2'b00) ? FAULT_BUS : FAULT_OK;
          end
        end
        WAIT_PC: begin
          if (s_valid) begin
            pcF   <= dnpc;
            snpcF <= next_seq_pc(dnpc);
            if (pc_misaligned(dnpc)) begin
              instF  <= 32'd0;
              faultF <= FAULT_ALIGN;
            end else begin
              faultF <= FAULT_OK;
            end
          end
        end
        default: begin
          pcF <= pcF;
        end
      endcase
    end
  end

  // Handshake outputs decoded purely from the registered state.
  always_comb begin
    arvalid = (state_r == ADDR);
    rready  = (state_r == WAIT_DATA);
    m_valid = (state_r == OUT);
    s_ready = (state_r == WAIT_PC);
  end

  // The read address is always the current PC, so it cannot move while
  // the request is pending.
  assign araddr = pcF;

endmodule

// File: tb/tb_fstage_fetch.sv
// Self-checking bench for fstage_fetch: a table of redirect vectors plus
// hand-written sequences for boot, latency, spurious inputs and reset
// during a read. Expected decode-side results go into a scoreboard queue
// when the redirect is driven and are popped when m_valid appears.
module tb_fstage_fetch;

  localparam logic [31:0] RPC = 32'h80000000;

  logic        clk;
  logic        rst;
  logic [31:0] dnpc;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] pcF;
  logic [31:0] instF;
  logic [31:0] snpcF;
  logic [1:0]  faultF;
  logic        m_valid;
  logic        m_ready;

  fstage_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .dnpc(dnpc), .s_valid(s_valid), .s_ready(s_ready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .pcF(pcF), .instF(instF), .snpcF(snpcF), .faultF(faultF),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] snpc;
    logic [1:0]  fault;
  } exp_t;

  typedef struct {
    logic [31:0] dnpc;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_stall;
    int          r_stall;
    int          m_stall;
    logic [31:0] exp_inst;
    logic [31:0] exp_snpc;
    logic [1:0]  exp_fault;
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] last_inst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive a PC from write-back for one cycle (state must be WAIT_PC).
  task automatic redirect(input logic [31:0] pc);
    check("s_ready_before_redirect", {31'd0, s_ready}, 32'd1);
    dnpc = pc;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Play the read-address side, optionally stalling arready.
  task automatic do_addr(input int stall, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (!arvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("arvalid_seen", {31'd0, arvalid}, 32'd1);
    check("araddr", araddr, exp_addr);
    for (int i = 0; i < stall; i++) begin
      arready = 1'b0;
      @(negedge clk);
      check("arvalid_held", {31'd0, arvalid}, 32'd1);
      check("araddr_stable", araddr, exp_addr);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  // Play the read-data side, optionally delaying rvalid.
  task automatic do_data(input int stall, input logic [31:0] d, input logic [1:0] resp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
    end
    check("rready", {31'd0, rready}, 32'd1);
    rdata = d;
    rresp = resp;
    rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
  endtask

  // Wait for decode output, compare with scoreboard, optionally stall m_ready.
  task automatic consume(input int stall);
    int n;
    exp_t e;
    n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("m_valid_seen", {31'd0, m_valid}, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      check("pcF", pcF, e.pc);
      check("instF", instF, e.inst);
      check("snpcF", snpcF, e.snpc);
      check("faultF", {30'd0, faultF}, {30'd0, e.fault});
      for (int i = 0; i < stall; i++) begin
        m_ready = 1'b0;
        @(negedge clk);
        check("m_valid_held", {31'd0, m_valid}, 32'd1);
        check("instF_stable", instF, e.inst);
        check("pcF_stable", pcF, e.pc);
      end
      last_inst = e.inst;
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("s_ready_after_out", {31'd0, s_ready}, 32'd1);
  endtask

  vec_t vecs[7];
  exp_t e;
  int cnt;

  initial begin
    vecs[0] = '{32'h80001000, 32'h00A00093, 2'b00, 5, 1, 4, 32'h00A00093, 32'h80001004, 2'b00};
    vecs[1] = '{32'h80000002, 32'h0,        2'b00, 0, 0, 0, 32'h00000000, 32'h80000006, 2'b01};
    vecs[2] = '{32'h80000100, 32'hDEADBEEF, 2'b10, 0, 2, 0, 32'hDEADBEEF, 32'h80000104, 2'b10};
    vecs[3] = '{32'hFFFFFFFC, 32'h12345678, 2'b00, 1, 0, 1, 32'h12345678, 32'h00000000, 2'b00};
    vecs[4] = '{32'h00000003, 32'h0,        2'b00, 0, 0, 2, 32'h00000000, 32'h00000007, 2'b01};
    vecs[5] = '{32'h80000200, 32'hCAFEF00D, 2'b01, 0, 0, 0, 32'hCAFEF00D, 32'h80000204, 2'b10};
    vecs[6] = '{32'h00000000, 32'h0BADC0DE, 2'b11, 2, 3, 0, 32'h0BADC0DE, 32'h00000004, 2'b10};

    rst = 1'b1;
    dnpc = 32'd0; s_valid = 1'b0; arready = 1'b0;
    rdata = 32'd0; rresp = 2'b00; rvalid = 1'b0; m_ready = 1'b0;
    last_inst = 32'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_rready", {31'd0, rready}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_pcF", pcF, RPC);
    check("rst_snpcF", snpcF, 32'h80000004);
    check("rst_instF", instF, 32'd0);
    check("rst_faultF", {30'd0, faultF}, 32'd0);

    // Boot: BOOT for one cycle, then ADDR at RESET_PC
    rst = 1'b0;
    check("boot_no_arvalid", {31'd0, arvalid}, 32'd0);
    @(negedge clk);
    check("boot_arvalid_2nd", {31'd0, arvalid}, 32'd1);
    sb.push_back('{RPC, 32'h00000413, 32'h80000004, 2'b00});
    do_addr(0, RPC);
    do_data(0, 32'h00000413, 2'b00);
    consume(0);

    // Table-driven redirects
    for (int v = 0; v < 7; v++) begin
      sb.push_back('{vecs[v].dnpc, vecs[v].exp_inst, vecs[v].exp_snpc, vecs[v].exp_fault});
      redirect(vecs[v].dnpc);
      if (vecs[v].dnpc[1:0] != 2'b00) begin
        check("misaligned_no_arvalid", {31'd0, arvalid}, 32'd0);
        check("misaligned_m_valid", {31'd0, m_valid}, 32'd1);
      end else begin
        do_addr(vecs[v].ar_stall, vecs[v].dnpc);
        do_data(vecs[v].r_stall, vecs[v].rdata, vecs[v].rresp);
      end
      consume(vecs[v].m_stall);
    end

    // Spurious rvalid in ADDR and OUT, spurious s_valid in OUT
    sb.push_back('{32'h80002000, 32'h11111111, 32'h80002004, 2'b00});
    redirect(32'h80002000);
    rdata = 32'h00000BAD; rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    check("spur_addr_still_arvalid", {31'd0, arvalid}, 32'd1);
    check("spur_addr_instF", instF, last_inst);
    do_addr(0, 32'h80002000);
    do_data(0, 32'h11111111, 2'b00);
    rdata = 32'h00000BAD; rvalid = 1'b1; dnpc = 32'h00000040; s_valid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; s_valid = 1'b0;
    check("spur_out_instF", instF, 32'h11111111);
    check("spur_out_pcF", pcF, 32'h80002000);
    consume(0);

    // Minimum latency with immediate arready/rvalid
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h22222222; rresp = 2'b00;
    sb.push_back('{32'h80003000, 32'h22222222, 32'h80003004, 2'b00});
    redirect(32'h80003000);
    cnt = 1;
    while (!m_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    arready = 1'b0; rvalid = 1'b0;
    check("latency_cycles", cnt, 32'd3);
    consume(0);

    // Reset in the middle of a read
    redirect(32'h80004000);
    do_addr(0, 32'h80004000);
    check("midread_rready", {31'd0, rready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_arvalid", {31'd0, arvalid}, 32'd0);
    check("midrst_rready", {31'd0, rready}, 32'd0);
    check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
    check("midrst_pcF", pcF, RPC);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{RPC, 32'h33333333, 32'h80000004, 2'b00});
    do_addr(0, RPC);
    do_data(0, 32'h33333333, 2'b00);
    consume(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
